// File: rtl/rom_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational ROM and
// queues (pc, word) pairs for decode. Optional macro: ROM_FETCH_ALIGN_CHECK_EN.
module rom_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] ROM_BYTES = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
`ifdef ROM_FETCH_ALIGN_CHECK_EN
  output logic        align_fault,
`endif
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [CW-1:0]  count;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  next_rd;
  logic [31:0]    mem_pc   [DEPTH];
  logic [31:0]    mem_data [DEPTH];
  logic           in_range;
  logic           pop;
  logic           push;

  // Valid/ready: a head entry transfers on any rising edge where inst_valid
  // and inst_ready are both high, except when redirect_valid flushes the queue.
  assign rom_addr   = fetch_pc;
  assign inst_valid = (count != '0);
  assign halted     = (state == HALT);
  assign in_range   = (fetch_pc <= (ROM_BYTES - 32'd4));
  assign pop        = inst_valid && inst_ready;
  assign push       = (state == RUN) && !redirect_valid && in_range &&
                      ((count != FULL) || pop);
  assign next_rd    = rd_ptr + 1'b1;

  // Entry storage carries no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_data[wr_ptr] <= rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      inst_data <= '0;
      inst_pc   <= '0;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
      state       <= (RESET_PC[1:0] != 2'b00) ? HALT : RUN;
      align_fault <= (RESET_PC[1:0] != 2'b00);
`else
      state     <= RUN;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
      state       <= (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
      align_fault <= (redirect_pc[1:0] != 2'b00);
`else
      state    <= RUN;
`endif
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= next_rd;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head registers track the entry that will sit at rd_ptr after this
      // edge; they hold their last value whenever the queue drains.
      if (pop) begin
        if (count > CW'(1)) begin
          inst_pc   <= mem_pc[next_rd];
          inst_data <= mem_data[next_rd];
        end else if (push) begin
          inst_pc   <= fetch_pc;
          inst_data <= rom_data;
        end
      end else if ((count == '0) && push) begin
        inst_pc   <= fetch_pc;
        inst_data <= rom_data;
      end
      if ((state == RUN) && !in_range) begin
        state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_queue.sv
// Directed bench for rom_fetch_queue: expected (pc, word) pairs are queued by
// the stimulus and popped by an independent monitor on each handshake.
module tb_rom_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  logic [63:0] exp_q[$];
  int vectors;
  int miscompares;

  rom_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
`ifdef ROM_FETCH_ALIGN_CHECK_EN
    .align_fault    (align_fault),
`endif
    .halted         (halted)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: the three words named in the plan, then an address tag.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1111_1111;
      32'h4:   return 32'h2222_2222;
      32'h8:   return 32'h3333_3333;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, rom_word(pc)});
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer is any edge with valid&ready and no flush.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pop: got pc %h data %h, expected nothing", inst_pc, inst_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({inst_pc, inst_data} !== e) begin
          miscompares++;
          $display("FAIL head_entry: got pc %h data %h, expected pc %h data %h",
                   inst_pc, inst_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_valid",  {31'b0, inst_valid}, 32'd0);
    check32("reset_halted", {31'b0, halted},     32'd0);
    check32("reset_addr",   rom_addr,            32'h0);
    check32("reset_pc",     inst_pc,             32'h0);
    check32("reset_data",   inst_data,           32'h0);
    rst = 1'b0;

    // First word visible one edge after release; then fill with stalled consumer.
    tick();
    check32("first_valid", {31'b0, inst_valid}, 32'd1);
    check32("first_pc",    inst_pc,             32'h0);
    check32("first_data",  inst_data,           32'h1111_1111);
    check32("first_addr",  rom_addr,            32'h4);
    repeat (4) tick();
    check32("full_addr_stuck", rom_addr, 32'h8);
    check32("full_head_pc",    inst_pc,  32'h0);

    // Release: push+pop every cycle while full.
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    inst_ready = 1'b1;
    tick();
    check32("stream_addr_a", rom_addr, 32'hC);
    tick();
    check32("stream_addr_b", rom_addr, 32'h10);
    repeat (3) tick();

    // Redirect with two entries queued and the consumer ready.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check32("redirect_flush_valid", {31'b0, inst_valid}, 32'd0);
    expect_pc(32'h40);
    expect_pc(32'h44);
    expect_pc(32'h48);
    tick();
    check32("redirect_head_valid", {31'b0, inst_valid}, 32'd1);
    check32("redirect_head_pc",    inst_pc,             32'h40);
    check32("redirect_head_data",  inst_data,           rom_word(32'h40));
    repeat (3) tick();

    // Run off the end of the ROM.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFF8;
    tick();
    redirect_valid = 1'b0;
    expect_pc(32'hFFF8);
    expect_pc(32'hFFFC);
    repeat (3) tick();
    check32("end_halted", {31'b0, halted},     32'd1);
    check32("end_valid",  {31'b0, inst_valid}, 32'd0);
    check32("end_addr",   rom_addr,            32'h1_0000);
    repeat (2) tick();
    check32("halt_no_push",   {31'b0, inst_valid}, 32'd0);
    check32("halt_head_hold", inst_pc,             32'hFFFC);
    check32("halt_stays",     {31'b0, halted},     32'd1);

    // Redirect out of HALT, queue two entries, then async reset mid-cycle.
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check32("unhalt", {31'b0, halted}, 32'd0);
    repeat (2) tick();
    check32("prereset_valid", {31'b0, inst_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check32("async_reset_valid", {31'b0, inst_valid}, 32'd0);
    check32("async_reset_pc",    inst_pc,             32'h0);
    check32("async_reset_addr",  rom_addr,            32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    inst_ready = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    repeat (3) tick();
    inst_ready = 1'b0;

`ifdef ROM_FETCH_ALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check32("align_fault_set", {31'b0, align_fault}, 32'd1);
    check32("align_halted",    {31'b0, halted},      32'd1);
    repeat (2) tick();
    check32("align_no_push",   {31'b0, inst_valid},  32'd0);
    check32("align_addr",      rom_addr,             32'h42);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check32("align_fault_clr", {31'b0, align_fault}, 32'd0);
`endif

    tick();
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_fetch_queue.md
Name: rom_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the 32-bit byte-addressed ROM (combinational read, big-endian word at readAddress..readAddress+3).
- Owns the fetch PC, drives the ROM address, captures each returned word with its PC into a small FIFO, and presents instructions to the decode stage over a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush, and halts at the end of ROM.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- DEPTH, 2, queue entries; power of two, ≥2.
- ROM_BYTES, 32'h0001_0000, ROM size in bytes; valid word addresses 0..ROM_BYTES-4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- rom_addr  output  32  byte address to ROM; always equals fetch_pc.
- rom_data  input  32  ROM word, valid combinationally in the same cycle.
- redirect_valid  input  1  load new fetch PC, flush queue.
- redirect_pc  input  32  target PC.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  consumer accepts head.
- inst_data  output  32  head instruction word.
- inst_pc  output  32  head PC.
- halted  output  1  fetch stopped (HALT state).

Behaviour:
- Reset, async, any time:
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=RUN.
  - inst_valid=0, inst_data=0, inst_pc=0, halted=0.
  - Entry storage need not be cleared.
  - Reset mid-operation discards all queued entries.
- States:
  - RUN: fetching.
  - HALT: not fetching.
  - RUN→HALT: at a clock edge when fetch_pc > ROM_BYTES-4 (unsigned) and no redirect.
  - HALT→RUN: only on redirect_valid.
  - halted=1 exactly in HALT.
- Pop: inst_valid && inst_ready at a clock edge removes the head.
- Push, RUN only, no redirect, in_range, and (count<DEPTH or pop this cycle):
  - Write {fetch_pc, rom_data} at the tail.
  - fetch_pc += 4, modulo 2^32.
  - Push and pop in the same cycle: count unchanged. Allowed when full.
- Full, no pop: no push; fetch_pc held; rom_addr stable.
- Empty: inst_valid=0; inst_data/inst_pc hold their last value.
- Latency: a word fetched at edge N is visible at the head after edge N. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle when the consumer is always ready.
- Redirect (priority over push/pop):
  - At the edge: count=0, pointers=0, fetch_pc=redirect_pc, state=RUN.
  - inst_valid=0 the following cycle; a pop coincident with redirect is ignored.
  - First push from the new PC occurs on the next edge.
- Head outputs come straight from the registered head entry; inst_valid = (count!=0).
- Out of range while in RUN: nothing is pushed. Entries already queued still drain normally.
- Word-aligned PCs are the contract. Misaligned PCs are fetched as-is (ROM handles byte addressing) unless the optional feature is enabled.

Optional Feature:
- Macro ROM_FETCH_ALIGN_CHECK_EN.
- Defined:
  - redirect_pc[1:0]!=0 loads fetch_pc but enters HALT instead of RUN.
  - Adds output port align_fault (1 bit). It sets at that edge and stays 1 until the next aligned redirect or reset.
  - The same check applies to RESET_PC at reset.
- Undefined:
  - No align_fault port.
  - Misaligned PCs are fetched normally and increment by 4.

Test Plan:
- Reset, ROM words 0x11111111,0x22222222,... at 0,4,8; inst_ready=1 → inst_valid from cycle 2; (pc,data) = (0,0x11111111),(4,0x22222222),(8,...) one per cycle.
- inst_ready=0 for 5 cycles → count=DEPTH=2, rom_addr stuck at 8; release → heads pc 0,4,8 in order, none lost or duplicated.
- Full queue with inst_ready=1 continuously → push+pop every cycle, count stays 2, rom_addr advances by 4 each cycle.
- redirect_valid with redirect_pc=0x40 while 2 entries queued and inst_ready=1 → next cycle inst_valid=0; the cycle after, head pc=0x40 with ROM[0x40].
- Redirect to 0xFFF8 (ROM_BYTES=0x10000) → pcs 0xFFF8, 0xFFFC delivered; halted=1 once fetch_pc=0x10000; no further pushes; redirect to 0 clears halted.
- Assert rst for one cycle while entries are queued → inst_valid=0 immediately (async); after release, fetch restarts at RESET_PC. With ROM_FETCH_ALIGN_CHECK_EN, redirect to 0x42 → align_fault=1, halted=1, no push.
